// File: rtl/n_bit_adder_sync_if.sv
// rtl/n_bit_adder_sync_if.sv - operand/result bundle for n_bit_adder_sync
// master drives operands and consumes results; slave is the adder side.
interface n_bit_adder_sync_if #(
  parameter int N = 16
) ();
  logic         in_valid;
  logic [N-1:0] input1;
  logic [N-1:0] input2;
  logic         out_valid;
  logic [N-1:0] answer;
  logic         carry_out;
  logic         overflow;

  modport master (
    output in_valid, input1, input2,
    input  out_valid, answer, carry_out, overflow
  );

  modport slave (
    input  in_valid, input1, input2,
    output out_valid, answer, carry_out, overflow
  );
endinterface

// File: rtl/n_bit_adder_sync.sv
// rtl/n_bit_adder_sync.sv - registered ripple-carry N-bit adder with carry and signed overflow
// N_BIT_ADDER_PIPE_EN splits the carry chain into two registered stages (latency 2 instead of 1).
module n_bit_adder_sync_rca #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  assign cout = c[W];
endmodule

module n_bit_adder_sync #(
  parameter int N = 16
) (
  input  logic              clk,
  input  logic              rst,
  n_bit_adder_sync_if.slave bus
);
  logic         out_valid_q, out_valid_d;
  logic [N-1:0] answer_q,    answer_d;
  logic         carry_out_q, carry_out_d;
  logic         overflow_q,  overflow_d;

`ifdef N_BIT_ADDER_PIPE_EN
  localparam int L = N / 2;
  localparam int H = N - L;

  logic         s1_valid_q,  s1_valid_d;
  logic [L-1:0] lo_sum_q,    lo_sum_d;
  logic         mid_carry_q, mid_carry_d;
  logic [H-1:0] a_hi_q,      a_hi_d;
  logic [H-1:0] b_hi_q,      b_hi_d;

  logic [L-1:0] lo_sum;
  logic         lo_cout;
  logic [H-1:0] hi_sum;
  logic         hi_cout;

  n_bit_adder_sync_rca #(.W(L)) u_lo (
    .a    (bus.input1[L-1:0]),
    .b    (bus.input2[L-1:0]),
    .cin  (1'b0),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  n_bit_adder_sync_rca #(.W(H)) u_hi (
    .a    (a_hi_q),
    .b    (b_hi_q),
    .cin  (mid_carry_q),
    .sum  (hi_sum),
    .cout (hi_cout)
  );

  always_comb begin
    s1_valid_d  = bus.in_valid;
    lo_sum_d    = lo_sum_q;
    mid_carry_d = mid_carry_q;
    a_hi_d      = a_hi_q;
    b_hi_d      = b_hi_q;
    if (bus.in_valid) begin
      lo_sum_d    = lo_sum;
      mid_carry_d = lo_cout;
      a_hi_d      = bus.input1[N-1:L];
      b_hi_d      = bus.input2[N-1:L];
    end
  end

  // Output stage only moves when stage 1 carries a live pair; otherwise it holds.
  always_comb begin
    out_valid_d = s1_valid_q;
    answer_d    = answer_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    if (s1_valid_q) begin
      answer_d    = {hi_sum, lo_sum_q};
      carry_out_d = hi_cout;
      overflow_d  = (a_hi_q[H-1] == b_hi_q[H-1]) && (hi_sum[H-1] != a_hi_q[H-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      lo_sum_q    <= '0;
      mid_carry_q <= 1'b0;
      a_hi_q      <= '0;
      b_hi_q      <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      lo_sum_q    <= lo_sum_d;
      mid_carry_q <= mid_carry_d;
      a_hi_q      <= a_hi_d;
      b_hi_q      <= b_hi_d;
    end
  end
`else
  logic [N-1:0] sum;
  logic         cout;

  n_bit_adder_sync_rca #(.W(N)) u_add (
    .a    (bus.input1),
    .b    (bus.input2),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  always_comb begin
    out_valid_d = bus.in_valid;
    answer_d    = answer_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    if (bus.in_valid) begin
      answer_d    = sum;
      carry_out_d = cout;
      overflow_d  = (bus.input1[N-1] == bus.input2[N-1]) && (sum[N-1] != bus.input1[N-1]);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      answer_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      answer_q    <= answer_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.answer    = answer_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_n_bit_adder_sync.sv
// tb/tb_n_bit_adder_sync.sv - directed and random checks of n_bit_adder_sync at N=16 and N=8
module tb_n_bit_adder_sync;
`ifdef N_BIT_ADDER_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  n_bit_adder_sync_if #(.N(16)) b16 ();
  n_bit_adder_sync_if #(.N(8))  b8 ();

  n_bit_adder_sync #(.N(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));
  n_bit_adder_sync #(.N(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));

  int    total = 0;
  int    bad   = 0;
  string phase = "init";

  // expected-result delay line per DUT (0 = N16, 1 = N8), plus held output values
  logic        mv [2][LAT];
  logic [15:0] ma [2][LAT];
  logic        mc [2][LAT];
  logic        mo [2][LAT];
  logic [15:0] ha [2];
  logic        hc [2];
  logic        ho [2];
  logic        nv [2];
  logic [15:0] na [2];
  logic        nc [2];
  logic        no [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s/%s got=%0h exp=%0h", phase, tag, got, exp);
    end
  endtask

  function automatic logic [17:0] ref16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic        ov;
    s  = {1'b0, a} + {1'b0, b};
    ov = (a[15] == b[15]) && (s[15] != a[15]);
    return {ov, s};
  endfunction

  function automatic logic [9:0] ref8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic       ov;
    s  = {1'b0, a} + {1'b0, b};
    ov = (a[7] == b[7]) && (s[7] != a[7]);
    return {ov, s};
  endfunction

  task automatic set16(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] ea, input logic ec, input logic eo);
    b16.in_valid = v;
    b16.input1   = a;
    b16.input2   = b;
    nv[0] = v; na[0] = ea; nc[0] = ec; no[0] = eo;
  endtask

  task automatic set8(input logic v, input logic [7:0] a, input logic [7:0] b);
    logic [9:0] r;
    r = ref8(a, b);
    b8.in_valid = v;
    b8.input1   = a;
    b8.input2   = b;
    nv[1] = v; na[1] = {8'h00, r[7:0]}; nc[1] = r[8]; no[1] = r[9];
  endtask

  task automatic tick();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int s = 0; s < LAT; s++) begin
          mv[d][s] = 1'b0; ma[d][s] = '0; mc[d][s] = 1'b0; mo[d][s] = 1'b0;
        end
        ha[d] = '0; hc[d] = 1'b0; ho[d] = 1'b0;
      end else begin
        for (int s = LAT - 1; s > 0; s--) begin
          mv[d][s] = mv[d][s-1]; ma[d][s] = ma[d][s-1];
          mc[d][s] = mc[d][s-1]; mo[d][s] = mo[d][s-1];
        end
        mv[d][0] = nv[d]; ma[d][0] = na[d]; mc[d][0] = nc[d]; mo[d][0] = no[d];
        if (mv[d][LAT-1]) begin
          ha[d] = ma[d][LAT-1]; hc[d] = mc[d][LAT-1]; ho[d] = mo[d][LAT-1];
        end
      end
    end
    #1;
    chk("v16",  b16.out_valid, mv[0][LAT-1]);
    chk("a16",  b16.answer,    ha[0]);
    chk("c16",  b16.carry_out, hc[0]);
    chk("o16",  b16.overflow,  ho[0]);
    chk("v8",   b8.out_valid,  mv[1][LAT-1]);
    chk("a8",   b8.answer,     ha[1][7:0]);
    chk("c8",   b8.carry_out,  hc[1]);
    chk("o8",   b8.overflow,   ho[1]);
  endtask

  task automatic idle16();
    set16(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < LAT; s++) begin
        mv[d][s] = 1'b0; ma[d][s] = '0; mc[d][s] = 1'b0; mo[d][s] = 1'b0;
      end
      ha[d] = '0; hc[d] = 1'b0; ho[d] = 1'b0;
    end
    set8(1'b0, 8'h00, 8'h00);

    phase = "reset";
    rst = 1'b1;
    set16(1'b1, 16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    idle16();
    tick();

    phase = "basic";
    set16(1'b1, 16'h0003, 16'h0005, 16'h0008, 1'b0, 1'b0);
    tick();
    idle16();
    repeat (3) tick();

    phase = "edges";
    set16(1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0); tick();
    set16(1'b1, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1); tick();
    set16(1'b1, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1); tick();
    set16(1'b1, 16'hFFFE, 16'h0003, 16'h0001, 1'b1, 1'b0); tick();
    idle16();
    repeat (3) tick();

    phase = "stream";
    set16(1'b1, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0); tick();
    set16(1'b1, 16'h0002, 16'h0002, 16'h0004, 1'b0, 1'b0); tick();
    set16(1'b1, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0); tick();
    idle16();
    repeat (2 + LAT) tick();

    phase = "midrst";
    set16(1'b1, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0); tick();
    idle16();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();

    phase = "random";
    for (int i = 0; i < 60; i++) begin
      logic [15:0] a, b;
      logic [17:0] r;
      logic [7:0]  c, e;
      a = 16'($urandom);
      b = 16'($urandom);
      c = 8'($urandom);
      e = 8'($urandom);
      r = ref16(a, b);
      set16(1'($urandom_range(0, 3) != 0), a, b, r[15:0], r[16], r[17]);
      set8(1'($urandom_range(0, 3) != 0), c, e);
      tick();
    end
    idle16();
    set8(1'b0, 8'h00, 8'h00);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/n_bit_adder_sync.md
Name: n_bit_adder_sync

Overview:
- Registered N-bit two's-complement/unsigned adder for the FFT datapath.
- Accumulates shifted partial products inside the 8-bit shift-add multiplier, with a 16-bit instance.
- Single clock domain.
- Sum is modulo 2^N, plus unsigned carry-out and signed-overflow flags.
- Valid-qualified, fully pipelined: accepts one operand pair per cycle.

Parameters:
- N, 16: operand/result width in bits; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operands on input1/input2 are valid this cycle
- input1  input  N  first addend
- input2  input  N  second addend
- out_valid  output  1  answer/carry_out/overflow updated with a new result this cycle
- answer  output  N  (input1 + input2) mod 2^N
- carry_out  output  1  unsigned carry out of bit N-1
- overflow  output  1  signed two's-complement overflow

One clock; reset is synchronous and active-high.

Behaviour:
- Reset: on a clk edge with rst=1, clear all registers (pipeline stages included).
  - answer=0, carry_out=0, overflow=0, out_valid=0.
  - rst has priority over in_valid.
  - Reset mid-operation discards any in-flight result; no out_valid pulse for it.
- Arithmetic:
  - {carry_out, answer} = input1 + input2 as an (N+1)-bit unsigned sum; no carry-in.
  - overflow = (input1[N-1] == input2[N-1]) && (answer[N-1] != input1[N-1]).
  - The same result is valid for signed and unsigned interpretation.
- Datapath: ripple carry chain of N full-adder cells (sum = a^b^c, cout = ab|ac|bc), bit 0 carry-in = 0.
- Default latency: 1 cycle.
  - Operands sampled at edge k with in_valid=1 give results and out_valid=1 after edge k.
  - out_valid follows in_valid delayed by exactly the latency.
- Hold rule:
  - When a cycle's in_valid=0, answer/carry_out/overflow hold their previous values.
  - out_valid is 0 for that slot.
- Throughput: one operand pair per cycle.
  - Back-to-back valid inputs produce back-to-back valid outputs, in order.
  - No backpressure; the consumer must take every out_valid result.
- No internal state beyond the pipeline registers; no wrap/saturation modes.

Optional Feature:
- Macro: N_BIT_ADDER_PIPE_EN.
- Defined: carry chain is split into two registered stages.
  - Stage 1 adds the low L = N/2 bits (integer division).
  - It registers the low sum, the mid carry, the high operand bits [N-1:L] and the valid bit.
  - Stage 2 adds the high N-L bits with the registered carry-in and computes carry_out and overflow.
  - Latency 2; throughput still 1/cycle; out_valid delayed 2 cycles.
  - Hold rule applies at the output stage.
  - Reset clears both stages.
- Not defined: single-stage, latency 1, as above.
- Arithmetic results are identical in both builds; only timing differs.

Test Plan:
- Reset: assert rst 2 cycles while in_valid=1, input1=16'h1234 -> answer=0, carry_out=0, overflow=0, out_valid=0 throughout and on the first cycle after release.
- Basic add, N=16: input1=16'h0003, input2=16'h0005, in_valid=1 -> after latency, answer=16'h0008, carry_out=0, overflow=0, out_valid=1 for one cycle.
- Unsigned wrap: 16'hFFFF + 16'h0001 -> answer=16'h0000, carry_out=1, overflow=0.
- Signed overflow:
  - 16'h7FFF + 16'h0001 -> answer=16'h8000, carry_out=0, overflow=1.
  - 16'h8000 + 16'h8000 -> answer=0, carry_out=1, overflow=1.
  - 16'hFFFE + 16'h0003 (-2+3) -> answer=16'h0001, carry_out=1, overflow=0.
- Streaming/hold: 3 back-to-back valid pairs (1+1, 2+2, 16'h00FF+16'h0001), then in_valid=0 for 2 cycles -> answers 2, 4, 16'h0100 on consecutive out_valid cycles; then out_valid=0 and answer holds 16'h0100. Repeat with N_BIT_ADDER_PIPE_EN defined: same values, one cycle later.
- Reset mid-stream (PIPE build): valid pair 16'h00FF+16'h0001, rst on the next edge -> no out_valid pulse, answer=0. Also random signed/unsigned compare vs. an (N+1)-bit reference model at N=8 and N=16.
